// File: rtl/group_fifo_pkg.sv
// Shared definitions for the SFTM -> DPM group FIFO.
//   rd_state_t : read-side FSM encoding (idle between groups / draining a group)
//   CNT_W      : width of the word/group/credit counters exposed as status
//   ptr_width  : address width needed for a given FIFO depth (minimum 1)
package group_fifo_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/group_fifo_mem.sv
// Storage array for the group FIFO.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous (show-ahead) read port
// Entries are not reset; a slot is only read after it has been written.
module group_fifo_mem
  import group_fifo_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sftm_dpm_group_fifo.sv
// Group-atomic buffer between the SFTM producer and the DPM consumer.
//   Write side : wr_valid/wr_data/wr_last in, wr_ready out. A word moves when
//                wr_valid && wr_ready (same rule on the read side with
//                rd_valid && rd_ready); valid never depends on ready.
//   Read side  : rd_valid/rd_data/rd_last out (show-ahead head), rd_ready in.
//   Status     : fifo_full, fifo_empty, fifo_count, credit_available,
//                drain_word, drain_last, groups_ready, protocol_err.
// The producer needs a credit to open a group; a credit comes back when the
// consumer pops a group's last word. The consumer sees a group only once its
// last word is stored, and then drains it without another group interleaving.
module sftm_dpm_group_fifo
  import group_fifo_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int GROUP_ROWS  = 4,
  parameter int MAX_CREDITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              credit_available,
  output logic              drain_word,
  output logic              drain_last,
  output logic [1:0]        groups_ready,
  output logic              protocol_err
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(GROUP_ROWS - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] groups_q, groups_d;
  logic [CNT_W-1:0] wr_row_q, wr_row_d;
  logic             in_group_q, in_group_d;
  logic             perr_q, perr_d;
  rd_state_t        state_q, state_d;

  logic             push, pop;
  logic [DATA_W:0]  head;

  group_fifo_mem #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({wr_last, wr_data}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign fifo_full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty       = (count_q == '0);
  assign fifo_count       = count_q;
  assign credit_available = (credits_q != '0);
  // A word inside an open group never needs a credit; a group start does.
  assign wr_ready         = !fifo_full && (in_group_q || credit_available);
  assign rd_valid         = (state_q == R_DRAIN) || (groups_q != '0);
  assign rd_last          = head[DATA_W];
  assign rd_data          = head[DATA_W-1:0];
  assign push             = wr_valid && wr_ready;
  assign pop              = rd_valid && rd_ready;
  assign drain_word       = pop;
  assign drain_last       = pop && rd_last;
  assign groups_ready     = (groups_q > CNT_W'(3)) ? 2'd3 : groups_q[1:0];
  assign protocol_err     = perr_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credits_d  = credits_q;
    groups_d   = groups_q;
    wr_row_d   = wr_row_q;
    in_group_d = in_group_q;
    perr_d     = perr_q;
    state_d    = state_q;

    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Credit taken at group open, returned at group-end pop; both together cancel.
    case ({push && !in_group_q, pop && rd_last})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase

    // A group leaves the "ready" pool when the consumer starts it, not when it ends.
    case ({push && wr_last, pop && (state_q == R_IDLE)})
      2'b10:   groups_d = groups_q + 1'b1;
      2'b01:   groups_d = groups_q - 1'b1;
      default: groups_d = groups_q;
    endcase

    if (push) begin
      // Both a short group and an over-long group are flagged; data is kept.
      if (wr_last != (wr_row_q == LAST_ROW)) perr_d = 1'b1;
      if (wr_last) begin
        in_group_d = 1'b0;
        wr_row_d   = '0;
      end else begin
        in_group_d = 1'b1;
        if (wr_row_q != LAST_ROW) wr_row_d = wr_row_q + 1'b1;
      end
    end

    case (state_q)
      R_IDLE:  if (pop && !rd_last) state_d = R_DRAIN;
      R_DRAIN: if (pop && rd_last)  state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= CNT_W'(MAX_CREDITS);
      groups_q   <= '0;
      wr_row_q   <= '0;
      in_group_q <= 1'b0;
      perr_q     <= 1'b0;
      state_q    <= R_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      groups_q   <= groups_d;
      wr_row_q   <= wr_row_d;
      in_group_q <= in_group_d;
      perr_q     <= perr_d;
      state_q    <= state_d;
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credits_q <= CNT_W'(MAX_CREDITS));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == '0)));

endmodule

// File: doc/sftm_dpm_group_fifo.md
Name: sftm_dpm_group_fifo

Overview:
- Inter-stage buffer between the SFTM producer and the DPM consumer.
- Owns credit accounting and group-atomic draining.
- Generates the status set the global controller consumes: credit_available, fifo_full, fifo_empty, fifo_count, drain_word, drain_last.
- Producer writes whole groups of GROUP_ROWS words; the consumer only sees a group once it is complete, then drains it without interruption.

Parameters:
- DATA_W, 64, width of one row word.
- FIFO_DEPTH, 8, word capacity; legal range 2..15 so that fifo_count fits 4 bits.
- GROUP_ROWS, 4, words per group; must be <= FIFO_DEPTH.
- MAX_CREDITS, 2, groups the producer may have outstanding; MAX_CREDITS*GROUP_ROWS must be <= FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- wr_valid  in  1  producer word valid
- wr_data  in  DATA_W  producer word
- wr_last  in  1  final word of group
- wr_ready  out  1  word accepted when wr_valid&&wr_ready
- rd_ready  in  1  consumer enable (DPM)
- rd_valid  out  1  consumer word available
- rd_data  out  DATA_W  head word (show-ahead)
- rd_last  out  1  head word is end of group
- fifo_full  out  1  count==FIFO_DEPTH
- fifo_empty  out  1  count==0
- fifo_count  out  4  stored words
- credit_available  out  1  credits!=0
- drain_word  out  1  pop occurred this cycle
- drain_last  out  1  popped word was group end
- groups_ready  out  2  complete groups not yet started by consumer (saturating view of internal counter)
- protocol_err  out  1  sticky group-length violation

Behaviour:
Reset (rst_n low, async):
- Pointers, count and groups counter = 0; credits = MAX_CREDITS.
- Read FSM = R_IDLE; protocol_err = 0; wr_row = 0; in_group = 0.
- Outputs: fifo_empty=1, fifo_full=0, credit_available=1, wr_ready=1, rd_valid=0.
- Reset mid-operation discards all stored data and credits.

Write side:
- wr_ready = !fifo_full && (in_group || credits!=0).
- Accepted word with !in_group: consumes one credit and sets in_group.
- wr_row counts 0..GROUP_ROWS-1.
- Accepted wr_last: clears in_group, increments groups counter, resets wr_row.
- protocol_err sets if wr_last arrives at wr_row!=GROUP_ROWS-1, or wr_row reaches GROUP_ROWS-1 without wr_last. The data is still stored and the group is closed at wr_last.
- Last flag is stored per entry alongside data.

Read FSM {R_IDLE, R_DRAIN}:
- rd_valid = (state==R_DRAIN) || (groups!=0).
- rd_data/rd_last = head entry, combinational from storage.
- Pop = rd_valid && rd_ready; drain_word = pop; drain_last = pop && rd_last. Both are combinational, same cycle as the pop.
- In R_IDLE, a pop decrements groups; if !rd_last go to R_DRAIN.
- In R_DRAIN, a pop with rd_last returns to R_IDLE.
- Pop of a word with rd_last returns one credit.

Timing:
- A written word raises fifo_count the next cycle.
- A group becomes eligible (rd_valid) the cycle after its wr_last is accepted; minimum write-to-read latency is 1 cycle.

Simultaneous events:
- Push+pop in the same cycle: count unchanged.
- Credit consume + credit return in the same cycle: credits unchanged. Credit return is never lost and never exceeds MAX_CREDITS.
- groups increment + decrement in the same cycle: unchanged.
- No write bypass when full; a pop in the same cycle frees a slot only for the next cycle.
- Pointers wrap modulo FIFO_DEPTH (non-power-of-2 supported via explicit compare-and-clear).

Assertions (sim-only):
- credits never exceeds MAX_CREDITS.
- Pop never occurs with count==0.

Decomposition:
- Package group_fifo_pkg holds:
  - typedef rd_state_t {R_IDLE, R_DRAIN};
  - function for pointer-width computation;
  - localparam for count width (4).
- One sub-module, group_fifo_mem: DATA_W+1 wide, FIFO_DEPTH-entry register array, synchronous write, asynchronous read.

Test Plan:
- Write one group of 4 words (wr_last on 4th), rd_ready=0 -> rd_valid stays 0 until the cycle after the 4th write; fifo_count=4, credit_available=1, groups_ready=1.
- Write 2 groups with MAX_CREDITS=2 -> credit_available=0 and wr_ready=0 for a 3rd group's first word. Drain 4 words -> drain_last pulses on the 4th pop and credit_available=1 the next cycle.
- Partial group (3 of 4 words written, no wr_last), rd_ready=1 -> rd_valid=0 throughout; 4th word with wr_last -> 4 consecutive pops with drain_word=1, drain_last only on the 4th.
- Toggle rd_ready mid-drain after 2 pops -> FSM holds R_DRAIN and rd_valid=1. Meanwhile new group writes complete -> the next group starts only after the current group's last pop; groups_ready goes 1->0 at that start.
- Simultaneous push and pop at count=5 -> count stays 5. Last-word pop coincident with first-word write of a new group -> credits unchanged.
- wr_last on the 2nd word -> protocol_err=1 and sticky; that short group still drains with rd_last on word 2. Then assert rst_n=0 mid-drain -> all outputs return to reset values asynchronously.
